// File: rtl/lfsr_bank.sv
// lfsr_bank: bank of independent Galois right-shift LFSRs with seed load, lockup recovery, match trigger and step counter
// Ports: clk/reset_in_n (async active-low); restart reloads SEEDS and clears counter/flags;
//   enable steps every channel; load/load_chan/load_data overwrite one channel;
//   match_en/match_chan/match_value arm the trigger; state packs all channels (channel 0 in MSBs);
//   trigger pulses on entry into match_value; lockup is sticky on zero recovery; step_count counts enable cycles.
module lfsr_bank #(
    parameter int                       WIDTH    = 32,
    parameter int                       CHANNELS = 4,
    parameter int                       CH_W     = 2,
    parameter logic [WIDTH-1:0]         POLY     = 32'hD0000001,
    parameter logic [CHANNELS*WIDTH-1:0] SEEDS   = 128'hC70337DB_7F4D514F_75377599_7D5937A3,
    parameter int                       CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      reset_in_n,
    input  logic                      restart,
    input  logic                      enable,
    input  logic                      load,
    input  logic [CH_W-1:0]           load_chan,
    input  logic [WIDTH-1:0]          load_data,
    input  logic                      match_en,
    input  logic [CH_W-1:0]           match_chan,
    input  logic [WIDTH-1:0]          match_value,
    output logic [CHANNELS*WIDTH-1:0] state,
    output logic                      trigger,
    output logic                      lockup,
    output logic [CNT_W-1:0]          step_count
);
    logic [CHANNELS*WIDTH-1:0] nxt;
    logic [WIDTH-1:0]          cur_m, nxt_m;
    logic                      rec, valid_m;
    // A zero channel would stay zero forever, so it is reseeded instead of shifted.
    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] seed);
        return (s == '0) ? seed : s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction
    always_comb begin
        nxt     = state;
        rec     = 1'b0;
        cur_m   = '0;
        nxt_m   = '0;
        valid_m = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            nxt[(CHANNELS-1-c)*WIDTH +: WIDTH] = (load && load_chan == CH_W'(c)) ? load_data :
                enable ? adv(state[(CHANNELS-1-c)*WIDTH +: WIDTH], SEEDS[(CHANNELS-1-c)*WIDTH +: WIDTH]) :
                state[(CHANNELS-1-c)*WIDTH +: WIDTH];
            rec = rec | (enable && !(load && load_chan == CH_W'(c)) && state[(CHANNELS-1-c)*WIDTH +: WIDTH] == '0);
            // Out-of-range match_chan never selects a channel, so valid_m stays low.
            if (match_chan == CH_W'(c)) begin
                valid_m = 1'b1;
                cur_m   = state[(CHANNELS-1-c)*WIDTH +: WIDTH];
                nxt_m   = nxt[(CHANNELS-1-c)*WIDTH +: WIDTH];
            end
        end
    end
    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            state      <= SEEDS;
            trigger    <= 1'b0;
            lockup     <= 1'b0;
            step_count <= '0;
        end else if (restart) begin
            state      <= SEEDS;
            trigger    <= 1'b0;
            lockup     <= 1'b0;
            step_count <= '0;
        end else begin
            state      <= nxt;
            trigger    <= match_en && valid_m && nxt_m != cur_m && nxt_m == match_value;
            lockup     <= lockup | rec;
            step_count <= enable ? step_count + CNT_W'(1) : step_count;
        end
    end
endmodule
